// File: rtl/pol2rec_seq.sv
// pol2rec_seq: iterative CORDIC polar-to-rectangular converter; define POL2REC_ROUND_EN for round-to-nearest output with saturation
module pol2rec_seq #(
  parameter int N_ITER = 24,
  parameter int GUARD  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [31:0] mod,
  input  logic [31:0] angle,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int W = 34 + GUARD;
  localparam logic [31:0] GAIN = 32'h9B74EDA8;
  localparam logic signed [31:0] D90  = 32'sh2D000000;
  localparam logic signed [31:0] D180 = 32'sh5A000000;
  localparam logic signed [31:0] ATAN [0:31] = '{
    32'h16800000, 32'h0D485399, 32'h0704A3A0, 32'h03900089,
    32'h01C9C553, 32'h00E51BCA, 32'h0072950D, 32'h00394B6C,
    32'h001CA5D3, 32'h000E52ED, 32'h00072977, 32'h000394BB,
    32'h0001CA5E, 32'h0000E52F, 32'h00007297, 32'h0000394C,
    32'h00001CA6, 32'h00000E53, 32'h00000729, 32'h00000395,
    32'h000001CA, 32'h000000E5, 32'h00000073, 32'h00000039,
    32'h0000001D, 32'h0000000E, 32'h00000007, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000};
  typedef enum logic [1:0] {IDLE, INIT, ROT, OUT} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [31:0] mod_r;
  logic signed [31:0] ang_r, zr;
  logic signed [W-1:0] xr, yr;
  logic neg, errp;
`ifdef POL2REC_ROUND_EN
  localparam logic signed [W-1:0] SMAX = W'(64'sh7FFFFFFF);
  function automatic logic [31:0] fin(input logic signed [W-1:0] v);
    logic signed [W-1:0] s;
    s = (v + W'(1 << (GUARD - 1))) >>> GUARD;
    return s > SMAX ? 32'h7FFFFFFF : s < -SMAX ? 32'h80000001 : 32'(s);
  endfunction
`else
  function automatic logic [31:0] fin(input logic signed [W-1:0] v);
    return 32'(v >>> GUARD);
  endfunction
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      mod_r <= '0;
      ang_r <= '0;
      zr    <= '0;
      xr    <= '0;
      yr    <= '0;
      neg   <= 1'b0;
      errp  <= 1'b0;
      x     <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mod_r <= mod;
          ang_r <= angle;
          busy  <= 1'b1;
          state <= INIT;
        end
        INIT: begin
          errp  <= ang_r > D180 || ang_r < -D180;
          neg   <= ang_r > D90 || ang_r < -D90;
          zr    <= ang_r > D90 ? ang_r - D180 : ang_r < -D90 ? ang_r + D180 : ang_r;
          // keep GUARD fraction bits of mod/K instead of flooring to 16Q16 first
          xr    <= W'((64'(mod_r) * 64'(GAIN)) >> (32 - GUARD));
          yr    <= '0;
          cnt   <= '0;
          state <= ROT;
        end
        ROT: begin
          xr    <= zr[31] ? xr + (yr >>> cnt) : xr - (yr >>> cnt);
          yr    <= zr[31] ? yr - (xr >>> cnt) : yr + (xr >>> cnt);
          zr    <= zr[31] ? zr + ATAN[cnt] : zr - ATAN[cnt];
          cnt   <= cnt == 5'(N_ITER - 1) ? '0 : cnt + 5'd1;
          state <= cnt == 5'(N_ITER - 1) ? OUT : ROT;
        end
        OUT: begin
          x     <= errp ? '0 : fin(neg ? -xr : xr);
          y     <= errp ? '0 : fin(neg ? -yr : yr);
          err   <= errp;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pol2rec_seq.sv
// tb_pol2rec_seq: randomized and directed checks of pol2rec_seq against a trigonometric reference
module tb_pol2rec_seq;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b1, start = 1'b0;
  logic [31:0] mod = '0, angle = '0;
  logic [31:0] x, y;
  logic busy, done, err;
  int tests = 0, fails = 0;

  pol2rec_seq dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .mod(mod), .angle(angle), .x(x), .y(y),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  function automatic bit in_range(input logic [31:0] a);
    return $signed(a) <= 32'sh5A000000 && $signed(a) >= -32'sh5A000000;
  endfunction

  function automatic real model(input logic [31:0] m, input logic [31:0] a, input bit im);
    real th;
    if (!in_range(a)) return 0.0;
    th = real'($signed(a)) / 8388608.0 * 3.141592653589793 / 180.0;
    return real'(m) * (im ? $sin(th) : $cos(th));
  endfunction

  task automatic launch(input logic [31:0] m, input logic [31:0] a);
    mod = m; angle = a; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock); #1;
      if (done) begin c = k; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({x, y, busy, done, err} !== 67'd0) begin
      fails++; $display("FAIL reset_state got x=%h y=%h b=%b d=%b e=%b want all 0", x, y, busy, done, err);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed;
    logic [31:0] ms [6] = '{32'h00010000, 32'h00010000, 32'h00020000, 32'h00000000, 32'h00010000, 32'h00010000};
    logic [31:0] as [6] = '{32'h00000000, 32'h2D000000, 32'hBC800000, 32'h12345678, 32'h5A000000, 32'hA6000000};
    real tl [6] = '{2.0, 2.0, 3.0, 0.0, 2.0, 2.0};
    int c;
    real dx, dy;
    for (int i = 0; i < 6; i++) begin
      launch(ms[i], as[i]);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL busy_rise[%0d] got %b want 1", i, busy); end
      wait_done(c);
      tests++;
      if (c !== 26) begin fails++; $display("FAIL latency[%0d] got %0d want 26", i, c); end
      dx = real'($signed(x)) - model(ms[i], as[i], 1'b0);
      dy = real'($signed(y)) - model(ms[i], as[i], 1'b1);
      tests++;
      if (dx > tl[i] || dx < -tl[i] || dy > tl[i] || dy < -tl[i] || err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL directed[%0d] got x=%h y=%h err=%b busy=%b want x=%f y=%f err=0 busy=0",
                 i, x, y, err, busy, model(ms[i], as[i], 1'b0), model(ms[i], as[i], 1'b1));
      end
    end
  endtask

  task automatic test_range_err;
    int c;
    real dx;
    launch(32'h00010000, 32'h5A800000);
    wait_done(c);
    tests++;
    if (c !== 26 || x !== 32'd0 || y !== 32'd0 || err !== 1'b1) begin
      fails++; $display("FAIL range_err got c=%0d x=%h y=%h err=%b want 26 0 0 1", c, x, y, err);
    end
    launch(32'h00010000, 32'h00000000);
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_hold got %b want 1", err); end
    wait_done(c);
    dx = real'($signed(x)) - 65536.0;
    tests++;
    if (err !== 1'b0 || dx > 2.0 || dx < -2.0) begin
      fails++; $display("FAIL err_clear got err=%b x=%h want err=0 x=00010000", err, x);
    end
  endtask

  task automatic test_busy_stall;
    logic [31:0] m0 = 32'h00030000, a0 = 32'h1E000000;
    int c = -1, extra = 0;
    real dx, dy;
    launch(m0, a0);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock); #1;
      if (done) begin c = k; break; end
      if (k == 4) begin start = 1'b1; mod = 32'h00050000; angle = 32'hE2000000; end
      if (k == 5) start = 1'b0;
      if (k == 7) enable = 1'b0;
      if (k == 14) enable = 1'b1;
    end
    tests++;
    if (c !== 33) begin fails++; $display("FAIL stall_latency got %0d want 33", c); end
    dx = real'($signed(x)) - model(m0, a0, 1'b0);
    dy = real'($signed(y)) - model(m0, a0, 1'b1);
    tests++;
    if (dx > 3.0 || dx < -3.0 || dy > 3.0 || dy < -3.0) begin
      fails++; $display("FAIL stall_value got x=%h y=%h want x=%f y=%f", x, y, model(m0, a0, 1'b0), model(m0, a0, 1'b1));
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL ignored_start got %0d active cycles want 0", extra); end
  endtask

  task automatic test_done_hold;
    int c;
    launch(32'h00008000, 32'h0F000000);
    wait_done(c);
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL done_hold got %b want 1", done); end
    enable = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_pulse_end got %b want 0", done); end
  endtask

  task automatic test_reset_mid;
    int c, seen = 0;
    real dx, dy;
    launch(32'h00010000, 32'h00000000);
    repeat (9) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({x, y, busy, done, err} !== 67'd0) begin
      fails++; $display("FAIL reset_mid got x=%h y=%h b=%b d=%b e=%b want all 0", x, y, busy, done, err);
    end
    @(posedge clock); #1 reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL reset_discard got %0d active cycles want 0", seen); end
    launch(32'h00018000, 32'hE2000000);
    wait_done(c);
    dx = real'($signed(x)) - model(32'h00018000, 32'hE2000000, 1'b0);
    dy = real'($signed(y)) - model(32'h00018000, 32'hE2000000, 1'b1);
    tests++;
    if (c !== 26 || dx > 3.0 || dx < -3.0 || dy > 3.0 || dy < -3.0) begin
      fails++; $display("FAIL after_reset got c=%0d x=%h y=%h", c, x, y);
    end
  endtask

  task automatic test_random;
    logic [31:0] m, a;
    int c;
    real dx, dy, tl;
    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(32'h00FFFFFF, 0);
      case ($urandom_range(7, 0))
        0: a = 32'h5A000001 + $urandom_range(32'h25FFFFFE, 0);
        1: a = 32'h80000000 + $urandom_range(32'h25FFFFFF, 0);
        default: a = $urandom_range(32'hB4000000, 0) - 32'h5A000000;
      endcase
      launch(m, a);
      wait_done(c);
      tests++;
      if (c !== 26) begin fails++; $display("FAIL rand_latency[%0d] got %0d want 26", i, c); end
      tests++;
      if (in_range(a)) begin
        tl = 4.0 + real'(m) / 2097152.0;
        dx = real'($signed(x)) - model(m, a, 1'b0);
        dy = real'($signed(y)) - model(m, a, 1'b1);
        if (dx > tl || dx < -tl || dy > tl || dy < -tl || err !== 1'b0) begin
          fails++;
          $display("FAIL rand[%0d] m=%h a=%h got x=%h y=%h err=%b want x=%f y=%f err=0",
                   i, m, a, x, y, err, model(m, a, 1'b0), model(m, a, 1'b1));
        end
      end else if (x !== 32'd0 || y !== 32'd0 || err !== 1'b1) begin
        fails++; $display("FAIL rand_err[%0d] a=%h got x=%h y=%h err=%b want 0 0 1", i, a, x, y, err);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_range_err;
    test_busy_stall;
    test_done_hold;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
